// File: rtl/mover_sequencer.sv
// Sequences DataMover S2MM then MM2S commands over a linear address range with per-channel status checking.
// First cmd_tvalid 1 cycle after start; cmd_tvalid/tdata held under cmd_tready backpressure; sts_tready always 1.
module mover_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int MAX_OUT  = 4,
    parameter int CNT_W    = 24,
    parameter int RST_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           cfg_mode,
    input  logic [ADDR_W-1:0]    cfg_base,
    input  logic [22:0]          cfg_btt,
    input  logic [CNT_W-1:0]     cfg_ncmd,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           err_sts,
    output logic                 s2mm_aresetn,
    output logic                 mm2s_aresetn,
    output logic [ADDR_W+39:0]   s2mm_cmd_tdata,
    output logic                 s2mm_cmd_tvalid,
    input  logic                 s2mm_cmd_tready,
    input  logic [7:0]           s2mm_sts_tdata,
    input  logic                 s2mm_sts_tvalid,
    output logic                 s2mm_sts_tready,
    output logic [ADDR_W+39:0]   mm2s_cmd_tdata,
    output logic                 mm2s_cmd_tvalid,
    input  logic                 mm2s_cmd_tready,
    input  logic [7:0]           mm2s_sts_tdata,
    input  logic                 mm2s_sts_tvalid,
    output logic                 mm2s_sts_tready
);
    typedef enum logic [2:0] {IDLE, WR_RUN, WR_DRAIN, RD_RUN, RD_DRAIN, FINISH} state_t;

    localparam int HOLD_W = $clog2(2 * RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_A = HOLD_W'(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_F = HOLD_W'(2 * RST_HOLD);
    localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

    state_t              state, state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [1:0]          mode_q;
    logic [22:0]         btt_q;
    logic [CNT_W-1:0]    ncmd_q, issued_q;
    logic [ADDR_W-1:0]   base_q, addr_q;
    logic [3:0]          outst_q, rcvd_q;
    logic                pend_q, error_q, done_q;
    logic [7:0]          err_sts_q;

    logic rd_phase, in_run, active, ready, start_ok;
    logic cmd_vld, cmd_rdy, accept, sts_vld, sts_bad;
    logic [7:0] sts_dat;
    logic [ADDR_W+39:0] cmd_word;

    assign ready    = (hold_cnt == HOLD_F);
    assign start_ok = (state == IDLE) && start && ready;
    assign rd_phase = (state == RD_RUN) || (state == RD_DRAIN);
    assign in_run   = (state == WR_RUN) || (state == RD_RUN);
    assign active   = in_run || (state == WR_DRAIN) || (state == RD_DRAIN);

    // pend_q keeps a presented command alive after an error so tvalid never retracts
    assign cmd_vld = (in_run && (issued_q < ncmd_q) && (outst_q < MAX_OUT_L) && !error_q) || pend_q;
    assign cmd_rdy = rd_phase ? mm2s_cmd_tready : s2mm_cmd_tready;
    assign accept  = cmd_vld && cmd_rdy;
    assign sts_vld = active && (rd_phase ? mm2s_sts_tvalid : s2mm_sts_tvalid);
    assign sts_dat = rd_phase ? mm2s_sts_tdata : s2mm_sts_tdata;
    assign sts_bad = sts_vld && ((outst_q == 4'd0) || !sts_dat[7] ||
                                 (sts_dat[6:4] != 3'b000) || (sts_dat[3:0] != rcvd_q));
    assign cmd_word = {4'b0000, issued_q[3:0], addr_q, 8'h00, 1'b1, btt_q};

    assign s2mm_cmd_tdata  = cmd_word;
    assign mm2s_cmd_tdata  = cmd_word;
    assign s2mm_cmd_tvalid = cmd_vld && !rd_phase;
    assign mm2s_cmd_tvalid = cmd_vld && rd_phase;
    assign s2mm_sts_tready = 1'b1;
    assign mm2s_sts_tready = 1'b1;
    assign s2mm_aresetn    = (hold_cnt >= HOLD_A);
    assign mm2s_aresetn    = (hold_cnt >= HOLD_A);
    assign busy    = (state != IDLE);
    assign done    = done_q;
    assign error   = error_q;
    assign err_sts = err_sts_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    if ((cfg_btt == 23'd0) || (cfg_ncmd == '0)) state_nxt = FINISH;
                    else if (cfg_mode == 2'd1)                  state_nxt = RD_RUN;
                    else                                        state_nxt = WR_RUN;
                end
            end
            WR_RUN: begin
                if (sts_bad || (accept && (issued_q + CNT_W'(1) == ncmd_q))) state_nxt = WR_DRAIN;
            end
            RD_RUN: begin
                if (sts_bad || (accept && (issued_q + CNT_W'(1) == ncmd_q))) state_nxt = RD_DRAIN;
            end
            WR_DRAIN: begin
                if ((outst_q == 4'd0) && !pend_q)
                    state_nxt = (mode_q[1] && !error_q && !sts_bad) ? RD_RUN : FINISH;
            end
            RD_DRAIN: begin
                if ((outst_q == 4'd0) && !pend_q) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            mode_q    <= 2'd0;
            btt_q     <= 23'd0;
            ncmd_q    <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            issued_q  <= '0;
            outst_q   <= 4'd0;
            rcvd_q    <= 4'd0;
            pend_q    <= 1'b0;
            error_q   <= 1'b0;
            err_sts_q <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == FINISH);
            if (hold_cnt != HOLD_F) hold_cnt <= hold_cnt + HOLD_W'(1);
            if (start_ok) begin
                mode_q    <= cfg_mode;
                btt_q     <= cfg_btt;
                ncmd_q    <= cfg_ncmd;
                base_q    <= cfg_base;
                addr_q    <= cfg_base;
                issued_q  <= '0;
                outst_q   <= 4'd0;
                rcvd_q    <= 4'd0;
                pend_q    <= 1'b0;
                error_q   <= (cfg_btt == 23'd0);
                err_sts_q <= 8'h00;
            end else begin
                if ((state == WR_DRAIN) && (state_nxt == RD_RUN)) begin
                    addr_q   <= base_q;
                    issued_q <= '0;
                    rcvd_q   <= 4'd0;
                    outst_q  <= 4'd0;
                end else begin
                    if (accept) begin
                        issued_q <= issued_q + CNT_W'(1);
                        addr_q   <= addr_q + ADDR_W'(btt_q);
                    end
                    if (sts_vld) rcvd_q <= rcvd_q + 4'd1;
                    case ({accept, sts_vld && (outst_q != 4'd0)})
                        2'b10:   outst_q <= outst_q + 4'd1;
                        2'b01:   outst_q <= outst_q - 4'd1;
                        default: outst_q <= outst_q;
                    endcase
                end
                pend_q <= cmd_vld && !cmd_rdy;
                if (sts_bad && !error_q) begin
                    error_q   <= 1'b1;
                    err_sts_q <= sts_dat;
                end
            end
        end
    end
endmodule

// File: tb/tb_mover_sequencer.sv
// Directed bench for mover_sequencer: table of whole runs plus hand sequences for errors, backpressure and reset.
`timescale 1ns/1ps
module tb_mover_sequencer;
    localparam int ADDR_W = 32, MAX_OUT = 4, CNT_W = 24, RST_HOLD = 16;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [22:0] cfg_btt = '0;
    logic [CNT_W-1:0] cfg_ncmd = '0;
    logic busy, done, error, s2mm_aresetn, mm2s_aresetn;
    logic [7:0] err_sts;
    logic [ADDR_W+39:0] s2mm_cmd_tdata, mm2s_cmd_tdata;
    logic s2mm_cmd_tvalid, mm2s_cmd_tvalid, s2mm_sts_tready, mm2s_sts_tready;
    logic s2mm_cmd_tready = 1'b1, mm2s_cmd_tready = 1'b1;
    logic s2mm_sts_tvalid = 1'b0, mm2s_sts_tvalid = 1'b0;
    logic [7:0] s2mm_sts_tdata = 8'h00, mm2s_sts_tdata = 8'h00;

    always #5 clk = ~clk;

    mover_sequencer #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode), .cfg_base(cfg_base),
        .cfg_btt(cfg_btt), .cfg_ncmd(cfg_ncmd), .busy(busy), .done(done), .error(error),
        .err_sts(err_sts), .s2mm_aresetn(s2mm_aresetn), .mm2s_aresetn(mm2s_aresetn),
        .s2mm_cmd_tdata(s2mm_cmd_tdata), .s2mm_cmd_tvalid(s2mm_cmd_tvalid), .s2mm_cmd_tready(s2mm_cmd_tready),
        .s2mm_sts_tdata(s2mm_sts_tdata), .s2mm_sts_tvalid(s2mm_sts_tvalid), .s2mm_sts_tready(s2mm_sts_tready),
        .mm2s_cmd_tdata(mm2s_cmd_tdata), .mm2s_cmd_tvalid(mm2s_cmd_tvalid), .mm2s_cmd_tready(mm2s_cmd_tready),
        .mm2s_sts_tdata(mm2s_sts_tdata), .mm2s_sts_tvalid(mm2s_sts_tvalid), .mm2s_sts_tready(mm2s_sts_tready)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W+39:0] cmd_word(input logic [3:0] tag, input logic [ADDR_W-1:0] addr,
                                                    input logic [22:0] btt);
        return {4'b0000, tag, addr, 8'h00, 1'b1, btt};
    endfunction

    typedef struct { int due; logic [7:0] dat; } sts_t;
    sts_t wq[$], rq[$];
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, after_err = 0;
    int out_w = 0, out_r = 0, max_out = 0, bad_wr_idx = -1;
    logic sts_en = 1'b1;
    logic [ADDR_W-1:0] cur_base = '0;
    logic [22:0] cur_btt = '0;
    logic [ADDR_W-1:0] wr_addr[64];

    // Monitor: checks every accepted command against the address/tag model and queues its status
    initial forever begin
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        if (done) done_cnt++;
        if (s2mm_cmd_tvalid && s2mm_cmd_tready) begin
            a = cur_base + ADDR_W'(wr_cnt) * ADDR_W'(cur_btt);
            check("s2mm_cmd", s2mm_cmd_tdata, cmd_word(4'(wr_cnt), a, cur_btt));
            if (error) after_err++;
            wq.push_back('{cyc + 3, (wr_cnt == bad_wr_idx) ? 8'hC2 : {4'h8, 4'(wr_cnt)}});
            if (wr_cnt < 64) wr_addr[wr_cnt] = a;
            wr_cnt++;
        end
        if (mm2s_cmd_tvalid && mm2s_cmd_tready) begin
            a = cur_base + ADDR_W'(rd_cnt) * ADDR_W'(cur_btt);
            check("mm2s_cmd", mm2s_cmd_tdata, cmd_word(4'(rd_cnt), a, cur_btt));
            if (error) after_err++;
            rq.push_back('{cyc + 3, {4'h8, 4'(rd_cnt)}});
            rd_cnt++;
        end
        out_w = out_w + int'(s2mm_cmd_tvalid && s2mm_cmd_tready) - int'(s2mm_sts_tvalid);
        out_r = out_r + int'(mm2s_cmd_tvalid && mm2s_cmd_tready) - int'(mm2s_sts_tvalid);
        if (out_w > max_out) max_out = out_w;
        if (out_r > max_out) max_out = out_r;
    end

    // Status responder: one status per cycle once its delay has elapsed
    initial forever begin
        sts_t e;
        @(posedge clk); #1;
        cyc++;
        if (sts_en && wq.size() > 0 && wq[0].due <= cyc) begin
            e = wq.pop_front();
            s2mm_sts_tvalid = 1'b1; s2mm_sts_tdata = e.dat;
        end else s2mm_sts_tvalid = 1'b0;
        if (sts_en && rq.size() > 0 && rq[0].due <= cyc) begin
            e = rq.pop_front();
            mm2s_sts_tvalid = 1'b1; mm2s_sts_tdata = e.dat;
        end else mm2s_sts_tvalid = 1'b0;
    end

    task automatic kick(input logic [1:0] mode, input logic [31:0] base, input logic [22:0] btt, input int ncmd);
        cur_base = base; cur_btt = btt;
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; after_err = 0; out_w = 0; out_r = 0; max_out = 0;
        wq.delete(); rq.delete();
        cfg_mode = mode; cfg_base = base; cfg_btt = btt; cfg_ncmd = CNT_W'(ncmd);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_timeout", 128'(n < 3000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_aresetn();
        int k = 0;
        while (!s2mm_aresetn && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("aresetn_lat", k, RST_HOLD);
        check("mm2s_aresetn", mm2s_aresetn, 1);
    endtask

    typedef struct {
        logic [1:0] mode; logic [31:0] base; logic [22:0] btt; int ncmd;
        int exp_wr; int exp_rd; logic exp_v1; logic exp_err; logic [7:0] exp_sts; int exp_lat;
    } vec_t;
    vec_t vt[7];

    initial begin
        int n;
        vt[0] = '{2'd2, 32'h0000_1000, 23'h1000, 8,  8, 8, 1'b1, 1'b0, 8'h00, 0};
        vt[1] = '{2'd0, 32'h0000_0020, 23'h0010, 3,  3, 0, 1'b1, 1'b0, 8'h00, 0};
        vt[2] = '{2'd1, 32'h0000_4000, 23'h0200, 5,  0, 5, 1'b1, 1'b0, 8'h00, 0};
        vt[3] = '{2'd0, 32'h0000_0100, 23'h0004, 20, 20, 0, 1'b1, 1'b0, 8'h00, 0};
        vt[4] = '{2'd2, 32'h0000_1000, 23'h1000, 0,  0, 0, 1'b0, 1'b0, 8'h00, 2};
        vt[5] = '{2'd0, 32'h0000_1000, 23'h0000, 4,  0, 0, 1'b0, 1'b1, 8'h00, 2};
        vt[6] = '{2'd3, 32'hFFFF_F000, 23'h1000, 2,  2, 2, 1'b1, 1'b0, 8'h00, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_s2mm_aresetn", s2mm_aresetn, 0);
        check("rst_mm2s_aresetn", mm2s_aresetn, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_sts", err_sts, 0);
        check("rst_cmd_vld", 128'({s2mm_cmd_tvalid, mm2s_cmd_tvalid}), 0);
        reset = 1'b0;
        wait_aresetn();
        // start sampled one cycle before the hold window closes must be ignored
        repeat (RST_HOLD - 1) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("early_start_ignored", busy, 0);

        for (int i = 0; i < 7; i++) begin
            kick(vt[i].mode, vt[i].base, vt[i].btt, vt[i].ncmd);
            check($sformatf("v%0d_first_vld", i), s2mm_cmd_tvalid | mm2s_cmd_tvalid, vt[i].exp_v1);
            wait_done(n);
            check($sformatf("v%0d_wr_cnt", i), wr_cnt, vt[i].exp_wr);
            check($sformatf("v%0d_rd_cnt", i), rd_cnt, vt[i].exp_rd);
            check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            check($sformatf("v%0d_error", i), error, vt[i].exp_err);
            check($sformatf("v%0d_err_sts", i), err_sts, vt[i].exp_sts);
            check($sformatf("v%0d_max_out", i), 128'(max_out <= MAX_OUT), 1);
            if (vt[i].exp_lat != 0) check($sformatf("v%0d_done_lat", i), n + 1, vt[i].exp_lat);
        end
        check("wrap_addr0", wr_addr[0], 32'hFFFF_F000);
        check("wrap_addr1", wr_addr[1], 32'h0000_0000);

        // SLVERR on the third write status
        bad_wr_idx = 2;
        kick(2'd0, 32'h0000_2000, 23'h0040, 8);
        wait_done(n);
        bad_wr_idx = -1;
        check("err_flag", error, 1);
        check("err_sts_val", err_sts, 8'hC2);
        check("err_no_mm2s", rd_cnt, 0);
        check("err_no_cmd_after", after_err, 0);
        check("err_stopped_early", 128'(wr_cnt < 8), 1);
        check("err_done_cnt", done_cnt, 1);

        // start while busy is ignored; the fresh start also clears the sticky error
        kick(2'd0, 32'h0000_3000, 23'h0080, 3);
        cfg_mode = 2'd1; cfg_base = 32'h0000_9000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check("busy_start_wr", wr_cnt, 3);
        check("busy_start_rd", rd_cnt, 0);
        check("busy_start_done", done_cnt, 1);
        check("error_cleared", error, 0);

        // tready low for 5 cycles, then status withheld so outstanding saturates
        sts_en = 1'b0;
        s2mm_cmd_tready = 1'b0;
        kick(2'd0, 32'h0000_5000, 23'h0100, 6);
        for (int j = 0; j < 5; j++) begin
            check("bp_vld", s2mm_cmd_tvalid, 1);
            check("bp_dat", s2mm_cmd_tdata, cmd_word(4'd0, 32'h0000_5000, 23'h0100));
            @(posedge clk); #1;
        end
        s2mm_cmd_tready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("bp_sat_cnt", wr_cnt, 4);
        check("bp_sat_vld", s2mm_cmd_tvalid, 0);
        check("bp_max_out", max_out, MAX_OUT);
        sts_en = 1'b1;
        wait_done(n);
        check("bp_wr_cnt", wr_cnt, 6);
        check("bp_done_cnt", done_cnt, 1);
        check("bp_error", error, 0);

        // reset during WR_RUN aborts without a done pulse
        kick(2'd0, 32'h0000_6000, 23'h0010, 8);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_err_sts", err_sts, 0);
        check("mid_rst_cmd_vld", 128'({s2mm_cmd_tvalid, mm2s_cmd_tvalid}), 0);
        check("mid_rst_aresetn", 128'({s2mm_aresetn, mm2s_aresetn}), 0);
        wq.delete(); rq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        wait_aresetn();
        repeat (RST_HOLD) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        kick(2'd0, 32'h0000_7000, 23'h0020, 3);
        wait_done(n);
        check("post_rst_wr", wr_cnt, 3);
        check("post_rst_done", done_cnt, 1);
        check("post_rst_error", error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
